// File: rtl/lsu_if.sv
// CPU-side request/response and RAM-side bus bundle for the load/store unit.
interface lsu_if #(
  parameter int ADDR_W = 13
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wr_mask;
  logic [31:0]       mem_rdata;
  logic              mem_rd_valid;

  // LSU view
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  mem_rdata, mem_rd_valid,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_ren, mem_wen, mem_addr, mem_wdata, mem_wr_mask
  );

  // CPU + RAM view
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output mem_rdata, mem_rd_valid,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_ren, mem_wen, mem_addr, mem_wdata, mem_wr_mask
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one byte/half/word access at a time between the CPU data
// port and a single-port block RAM, with alignment checking and load extension.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | drive one-cycle mem_ren or mem_wen
// WAIT  | load issued, waiting for mem_rd_valid
// RESP  | one-cycle response pulse to the CPU
module lsu #(
  parameter int ADDR_W = 13
) (
  input  logic  clk,
  input  logic  rst,
  lsu_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state;
  logic              we_q;
  logic              sgn_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        mask_q;
  logic [31:0]       rdata_q;

  logic              accept;
  logic              bad_req;
  logic [3:0]        st_mask;
  logic [31:0]       st_wdata;
  logic [31:0]       ld_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign accept = bus.req_valid & bus.req_ready;

  // Alignment / reserved-size check on the incoming request
  always_comb begin
    bad_req = 1'b0;
    case (bus.req_size)
      2'b00:   bad_req = 1'b0;
      2'b01:   bad_req = bus.req_addr[0];
      2'b10:   bad_req = |bus.req_addr[1:0];
      default: bad_req = 1'b1;
    endcase
  end

  // Store byte mask and lane-replicated write data; mask bit 3-k covers lane k
  always_comb begin
    st_mask  = 4'b0000;
    st_wdata = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        st_mask  = 4'b1000 >> bus.req_addr[1:0];
        st_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        st_mask  = bus.req_addr[1] ? 4'b0011 : 4'b1100;
        st_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        st_mask  = 4'b1111;
        st_wdata = bus.req_wdata;
      end
    endcase
  end

  // Lane extraction and sign/zero extension of returned read data
  always_comb begin
    ld_byte = bus.mem_rdata[7:0];
    case (lane_q)
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_data = {{24{ld_byte[7] & sgn_q}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & sgn_q}}, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  // Sequencer and request/memory-side registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            sgn_q   <= bus.req_signed;
            size_q  <= bus.req_size;
            lane_q  <= bus.req_addr[1:0];
            err_q   <= bad_req;
            rdata_q <= '0;
            if (bad_req) begin
              // Rejected requests never touch the RAM-side registers
              state <= S_RESP;
            end else begin
              state  <= S_ISSUE;
              addr_q <= bus.req_addr;
              if (bus.req_we) begin
                wdata_q <= st_wdata;
                mask_q  <= st_mask;
              end
            end
          end
        end
        S_ISSUE: state <= we_q ? S_RESP : S_WAIT;
        S_WAIT: begin
          if (bus.mem_rd_valid) begin
            rdata_q <= ld_data;
            state   <= S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state == S_IDLE) & ~rst;
  assign bus.resp_valid  = (state == S_RESP);
  assign bus.resp_err    = (state == S_RESP) & err_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.mem_ren     = (state == S_ISSUE) & ~we_q;
  assign bus.mem_wen     = (state == S_ISSUE) & we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_wr_mask = bus.mem_wen ? mask_q : 4'b0000;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a small RAM model and a response scoreboard.
module tb_lsu;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   ren_cnt;
  int   wen_cnt;

  logic [32:0] sb[$];
  logic [32:0] sb_e;

  logic [31:0] ram [0:2047];
  logic [31:0] ram_rd;
  logic        ram_rv;
  logic        inj_rv;

  lsu_if #(.ADDR_W(13)) bus ();

  lsu #(.ADDR_W(13)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata    = ram_rd;
  assign bus.mem_rd_valid = ram_rv | inj_rv;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (m[3-k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  // RAM model: one-cycle read latency, masked byte writes
  always @(posedge clk) begin
    ram_rv <= bus.mem_ren;
    if (bus.mem_ren) ram_rd <= ram[bus.mem_addr[12:2]];
    if (bus.mem_wen)
      ram[bus.mem_addr[12:2]] <= merge(ram[bus.mem_addr[12:2]], bus.mem_wdata, bus.mem_wr_mask);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor and memory-strobe counters
  always @(negedge clk) begin
    if (bus.mem_ren) ren_cnt++;
    if (bus.mem_wen) wen_cnt++;
    if (bus.mem_ren) chk("load_mask_zero", 32'(bus.mem_wr_mask), 32'd0);
    if (bus.resp_valid) begin
      chk("resp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        sb_e = sb.pop_front();
        chk("resp_err", 32'(bus.resp_err), 32'(sb_e[32]));
        chk("resp_rdata", bus.resp_rdata, sb_e[31:0]);
      end
    end
  end

  task automatic do_op(input string tag, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [12:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata,
                       input logic [3:0] exp_mask, input logic [31:0] exp_wd);
    int ren0, wen0;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    ren0 = ren_cnt;
    wen0 = wen_cnt;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    sb.push_back({exp_err, exp_rdata});
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
    if (exp_err) begin
      chk({tag, "_err_resp"}, 32'(bus.resp_valid), 32'd1);
    end else if (we) begin
      chk({tag, "_wen"}, 32'(bus.mem_wen), 32'd1);
      chk({tag, "_ren"}, 32'(bus.mem_ren), 32'd0);
      chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(addr));
      chk({tag, "_wdata"}, bus.mem_wdata, exp_wd);
      chk({tag, "_mask"}, 32'(bus.mem_wr_mask), 32'(exp_mask));
      @(negedge clk);
      chk({tag, "_resp"}, 32'(bus.resp_valid), 32'd1);
    end else begin
      chk({tag, "_ren"}, 32'(bus.mem_ren), 32'd1);
      chk({tag, "_wen"}, 32'(bus.mem_wen), 32'd0);
      chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(addr));
      @(negedge clk);
      chk({tag, "_no_early_resp"}, 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      chk({tag, "_resp"}, 32'(bus.resp_valid), 32'd1);
    end
    @(negedge clk);
    chk({tag, "_resp_done"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_ren_count"}, 32'(ren_cnt - ren0), (exp_err || we) ? 32'd0 : 32'd1);
    chk({tag, "_wen_count"}, 32'(wen_cnt - wen0), (!exp_err && we) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ren0;
    checks = 0; failures = 0; ren_cnt = 0; wen_cnt = 0;
    inj_rv = 1'b0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_ren", 32'(bus.mem_ren), 32'd0);
    chk("rst_wen", 32'(bus.mem_wen), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mask", 32'(bus.mem_wr_mask), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // Stores and loads from the plan
    do_op("st_b5", 1, 2'b00, 0, 13'h0005, 32'h000000AB, 0, 32'h0, 4'b0100, 32'hABABABAB);
    do_op("st_w4", 1, 2'b10, 0, 13'h0004, 32'h1234F678, 0, 32'h0, 4'b1111, 32'h1234F678);
    do_op("ld_b5s", 0, 2'b00, 1, 13'h0005, 32'h0, 0, 32'hFFFFFFF6, 4'b0, 32'h0);
    do_op("ld_b5u", 0, 2'b00, 0, 13'h0005, 32'h0, 0, 32'h000000F6, 4'b0, 32'h0);
    do_op("ld_h6s", 0, 2'b01, 1, 13'h0006, 32'h0, 0, 32'h00001234, 4'b0, 32'h0);
    do_op("ld_h4s", 0, 2'b01, 1, 13'h0004, 32'h0, 0, 32'hFFFFF678, 4'b0, 32'h0);
    do_op("ld_b7u", 0, 2'b00, 0, 13'h0007, 32'h0, 0, 32'h00000012, 4'b0, 32'h0);
    do_op("st_w10", 1, 2'b10, 0, 13'h0010, 32'hDEADBEEF, 0, 32'h0, 4'b1111, 32'hDEADBEEF);
    do_op("ld_w10", 0, 2'b10, 0, 13'h0010, 32'h0, 0, 32'hDEADBEEF, 4'b0, 32'h0);
    do_op("st_h12", 1, 2'b01, 0, 13'h0012, 32'h00008001, 0, 32'h0, 4'b0011, 32'h80018001);
    do_op("ld_h12s", 0, 2'b01, 1, 13'h0012, 32'h0, 0, 32'hFFFF8001, 4'b0, 32'h0);
    do_op("st_b13", 1, 2'b00, 0, 13'h0013, 32'h0000005A, 0, 32'h0, 4'b0001, 32'h5A5A5A5A);
    do_op("ld_w10b", 0, 2'b10, 1, 13'h0010, 32'h0, 0, 32'h5A01BEEF, 4'b0, 32'h0);

    // Rejected requests
    do_op("err_ld_h3", 0, 2'b01, 1, 13'h0003, 32'h0, 1, 32'h0, 4'b0, 32'h0);
    do_op("err_st_w2", 1, 2'b10, 0, 13'h0002, 32'hFFFFFFFF, 1, 32'h0, 4'b0, 32'h0);
    do_op("err_sz3", 0, 2'b11, 0, 13'h0000, 32'h0, 1, 32'h0, 4'b0, 32'h0);

    // Back-to-back loads with req_valid held high
    @(negedge clk);
    ren0 = ren_cnt;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 13'h0010;
    sb.push_back({1'b0, 32'h5A01BEEF});
    sb.push_back({1'b0, 32'h5A01BEEF});
    @(negedge clk);
    chk("b2b_ready_t1", 32'(bus.req_ready), 32'd0);
    chk("b2b_ren_t1", 32'(bus.mem_ren), 32'd1);
    @(negedge clk);
    chk("b2b_ready_t2", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("b2b_ready_t3", 32'(bus.req_ready), 32'd0);
    chk("b2b_resp_t3", 32'(bus.resp_valid), 32'd1);
    @(negedge clk);
    chk("b2b_ready_t4", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("b2b_ren_t5", 32'(bus.mem_ren), 32'd1);
    chk("b2b_ready_t5", 32'(bus.req_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("b2b_resp_t7", 32'(bus.resp_valid), 32'd1);
    @(negedge clk);
    chk("b2b_ren_total", 32'(ren_cnt - ren0), 32'd2);
    chk("b2b_sb_drained", 32'(sb.size()), 32'd0);

    // Reset while waiting for load data
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 13'h0005;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rw_ren", 32'(bus.mem_ren), 32'd1);
    @(negedge clk);
    chk("rw_rd_valid_present", 32'(bus.mem_rd_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    inj_rv = 1'b1;
    chk("rw_no_resp", 32'(bus.resp_valid), 32'd0);
    chk("rw_ready_in_rst", 32'(bus.req_ready), 32'd0);
    chk("rw_addr", 32'(bus.mem_addr), 32'd0);
    chk("rw_wdata", bus.mem_wdata, 32'd0);
    chk("rw_mask", 32'(bus.mem_wr_mask), 32'd0);
    chk("rw_rdata", bus.resp_rdata, 32'd0);
    chk("rw_ren_off", 32'(bus.mem_ren), 32'd0);
    chk("rw_wen_off", 32'(bus.mem_wen), 32'd0);
    rst = 1'b0;
    #1;
    chk("rw_ready_after", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    inj_rv = 1'b0;
    chk("rw_late_rv_ignored", 32'(bus.resp_valid), 32'd0);
    chk("rw_ready_idle", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    chk("rw_still_quiet", 32'(bus.resp_valid), 32'd0);
    do_op("post_rw_ld", 0, 2'b00, 1, 13'h0006, 32'h0, 0, 32'h00000034, 4'b0, 32'h0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the CPU data port and the single-port block RAM. Accepts one byte/half/word load or store at a time and enforces alignment. Drives the RAM's byte-address, read-enable, write-enable, lane-replicated write data and write mask, and extracts and sign/zero-extends the addressed lane from returned read data. Returns each completed access to the CPU as a one-cycle response pulse.

## Interface
- ADDR_W, 13, byte-address width; matches the RAM address port.
- clk  in  1  clock; everything on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request strobe.
- req_ready  out  1  LSU can accept; high only in IDLE and rst low.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (error).
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or reserved-size request; valid with resp_valid.
- mem_ren  out  1  RAM read enable.
- mem_wen  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM byte address; low two bits ignored by RAM.
- mem_wdata  out  32  lane-replicated store data.
- mem_wr_mask  out  4  byte mask: bit3→[7:0], bit2→[15:8], bit1→[23:16], bit0→[31:24].
- mem_rdata  in  32  RAM read data, valid with mem_rd_valid.
- mem_rd_valid  in  1  RAM read-data strobe, one cycle after mem_ren.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Accept = req_valid & req_ready in IDLE; latch we/size/signed/addr/wdata.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0; size 11 always errors. Error: IDLE→RESP with resp_err=1, resp_rdata=0, no mem_ren/mem_wen ever asserted.
- Lane k = addr[1:0]; lane k occupies bits [8k+7:8k], mask bit 3-k.
- Store masks: byte k → one bit (addr0=1000, addr3=0001); half addr0=1100, addr2=0011; word=1111.
- Store data: byte replicated to all four lanes; half replicated to both halves; word unchanged.
- Store: IDLE→ISSUE (mem_wen=1 exactly one cycle)→RESP.
- Load: IDLE→ISSUE (mem_ren=1 exactly one cycle, mem_wr_mask=0)→WAIT; in WAIT capture on mem_rd_valid, extract lane(s), extend per req_signed→RESP. No mem_rd_valid: stay in WAIT.
- Load extraction: byte from lane k; half from [15:0] (addr1=0) or [31:16] (addr1=1); word = mem_rdata.
- RESP: resp_valid=1 for one cycle, →IDLE.
- mem_rd_valid outside WAIT ignored.
- mem_addr, mem_wdata, mem_wr_mask registered; hold last value outside ISSUE; mem_wr_mask forced 0 when mem_wen=0.

## Timing
- Acceptance in cycle T.
- Store: mem_wen at T+1; resp_valid at T+2; throughput one store per 3 cycles.
- Load: mem_ren at T+1; mem_rd_valid at T+2; resp_valid and data at T+3; one load per 4 cycles.
- Error: resp_valid/resp_err at T+1.
- req_ready deasserted from T+1 until cycle after RESP. New request accepted earliest at RESP+1.
- Reset values: state IDLE; req_ready=0 during rst, 1 first cycle after; resp_valid, resp_err, mem_ren, mem_wen=0; resp_rdata, mem_addr, mem_wdata, mem_wr_mask=0.
- rst in any state, same edge: return to IDLE, drop pending access, no resp_valid. A mem_rd_valid arriving after reset is ignored.
- rst in ISSUE-cycle store: write enable sampled by RAM that edge; LSU guarantees no further memory activity.

## Test plan
- Store byte 0xAB at 0x0005 → T+1: mem_wen=1, mem_addr=0x0005, mem_wdata=0xABABABAB, mem_wr_mask=0100; T+2: resp_valid=1, resp_err=0.
- RAM word at 0x0004 = 0x1234F678; load byte 0x0005 signed → T+1 mem_ren=1; T+3 resp_rdata=0xFFFFFFF6. Unsigned → 0x000000F6. Half 0x0006 signed → 0x00001234.
- Store word 0xDEADBEEF at 0x0010 (mask 1111), then load word 0x0010 → resp_rdata=0xDEADBEEF.
- Load half at 0x0003; store word at 0x0002; req_size=11 at 0x0000 → each: resp_valid, resp_err=1 at T+1, resp_rdata=0, mem_ren/mem_wen never high.
- Hold req_valid high for two loads → req_ready low T+1..T+3; second accepted at T+4; exactly one mem_ren per request.
- Assert rst in WAIT with mem_rd_valid arriving same/next cycle → no resp_valid; all outputs zero; req_ready=1 after rst drops; next load completes normally.
